// File: rtl/rect_fill_engine.sv
// Rectangle-fill engine: polls an SRAM command mailbox, clips the rectangle to
// the screen, writes one pixel per clock into the VGA buffer, then clears "go".
module rect_fill_engine #(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned RD_LAT   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [7:0]  sram_address,
  output logic        sram_clken,
  output logic        sram_chipselect,
  output logic        sram_write,
  output logic [31:0] sram_writedata,
  output logic [3:0]  sram_byteenable,
  input  logic [31:0] sram_readdata,
  output logic [18:0] vga_buf_address,
  output logic        vga_buf_clken,
  output logic        vga_buf_chipselect,
  output logic        vga_buf_write,
  output logic [7:0]  vga_buf_writedata,
  output logic        busy,
  output logic [15:0] rect_count
);

  localparam int unsigned AW = 19;
  localparam int unsigned CW = $clog2(RD_LAT + 2);
  localparam logic [CW-1:0] LAT  = CW'(RD_LAT);
  // Extra poll phase used only out of reset so the first issue lands one cycle after release.
  localparam logic [CW-1:0] PRE  = CW'(RD_LAT + 1);
  localparam logic [9:0]    XMAX = 10'(SCREEN_W - 1);
  localparam logic [9:0]    YMAX = 10'(SCREEN_H - 1);

  typedef enum logic [2:0] {POLL, FETCH, CLIP, DRAW, ACK} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic [9:0]    x1, y1, x2, y2, x1_d, y1_d, x2_d, y2_d;
  logic [7:0]    colour, colour_d;
  logic [9:0]    x, y, x_d, y_d;
  logic [AW-1:0] row_base, row_base_d;
  logic [9:0]    x2c, y2c;

  logic [7:0]    sram_address_d;
  logic          sram_chipselect_d, sram_write_d;
  logic [AW-1:0] vga_buf_address_d;
  logic          vga_buf_write_d;
  logic [7:0]    vga_buf_writedata_d;
  logic          busy_d;
  logic [15:0]   rect_count_d;

  assign sram_clken      = 1'b1;
  assign vga_buf_clken   = 1'b1;
  assign sram_writedata  = 32'd0;
  assign sram_byteenable = 4'hF;

  assign x2c = (x2 > XMAX) ? XMAX : x2;
  assign y2c = (y2 > YMAX) ? YMAX : y2;

  // row * SCREEN_W as a sum of shifted copies of row, one per set bit of the stride.
  function automatic logic [AW-1:0] row_offset(input logic [9:0] row);
    logic [AW-1:0] acc;
    acc = '0;
    for (int i = 0; i < 19; i++) begin
      if (((SCREEN_W >> i) & 32'd1) != 32'd0) acc = acc + (AW'(row) << i);
    end
    return acc;
  endfunction

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    idx_d        = idx;
    x1_d         = x1;
    y1_d         = y1;
    x2_d         = x2;
    y2_d         = y2;
    colour_d     = colour;
    x_d          = x;
    y_d          = y;
    row_base_d   = row_base;
    rect_count_d = rect_count;

    unique case (state)
      POLL: begin
        if (cnt == PRE) begin
          cnt_d = '0;
        end else if (cnt == LAT) begin
          cnt_d = '0;
          if (sram_readdata != 32'd0) begin
            state_d = FETCH;
            idx_d   = 3'd1;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      FETCH: begin
        if (cnt == LAT) begin
          cnt_d = '0;
          case (idx)
            3'd1:    x1_d     = sram_readdata[9:0];
            3'd2:    y1_d     = sram_readdata[9:0];
            3'd3:    x2_d     = sram_readdata[9:0];
            3'd4:    y2_d     = sram_readdata[9:0];
            default: colour_d = sram_readdata[7:0];
          endcase
          if (idx == 3'd5) state_d = CLIP;
          else             idx_d   = idx + 3'd1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      CLIP: begin
        if (x1 > x2c || y1 > y2c) begin
          state_d = ACK;
        end else begin
          x_d        = x1;
          y_d        = y1;
          row_base_d = row_offset(y1);
          state_d    = DRAW;
        end
      end
      DRAW: begin
        if (x == x2c) begin
          if (y == y2c) begin
            state_d = ACK;
          end else begin
            x_d        = x1;
            y_d        = y + 10'd1;
            row_base_d = row_base + AW'(SCREEN_W);
          end
        end else begin
          x_d = x + 10'd1;
        end
      end
      ACK: begin
        state_d      = POLL;
        cnt_d        = '0;
        rect_count_d = rect_count + 16'd1;
      end
      default: begin
        state_d = POLL;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    sram_address_d      = (state_d == FETCH) ? 8'(idx_d) : 8'd0;
    sram_chipselect_d   = ((state_d == POLL || state_d == FETCH) && cnt_d == '0) ||
                          (state_d == ACK);
    sram_write_d        = (state_d == ACK);
    vga_buf_write_d     = (state_d == DRAW);
    vga_buf_address_d   = vga_buf_write_d ? (row_base_d + AW'(x_d)) : '0;
    vga_buf_writedata_d = vga_buf_write_d ? colour_d : 8'd0;
    busy_d              = (state_d != POLL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= POLL;
      cnt                <= PRE;
      idx                <= '0;
      x1                 <= '0;
      y1                 <= '0;
      x2                 <= '0;
      y2                 <= '0;
      colour             <= '0;
      x                  <= '0;
      y                  <= '0;
      row_base           <= '0;
      sram_address       <= '0;
      sram_chipselect    <= 1'b0;
      sram_write         <= 1'b0;
      vga_buf_address    <= '0;
      vga_buf_chipselect <= 1'b0;
      vga_buf_write      <= 1'b0;
      vga_buf_writedata  <= '0;
      busy               <= 1'b0;
      rect_count         <= '0;
    end else begin
      state              <= state_d;
      cnt                <= cnt_d;
      idx                <= idx_d;
      x1                 <= x1_d;
      y1                 <= y1_d;
      x2                 <= x2_d;
      y2                 <= y2_d;
      colour             <= colour_d;
      x                  <= x_d;
      y                  <= y_d;
      row_base           <= row_base_d;
      sram_address       <= sram_address_d;
      sram_chipselect    <= sram_chipselect_d;
      sram_write         <= sram_write_d;
      vga_buf_address    <= vga_buf_address_d;
      vga_buf_chipselect <= vga_buf_write_d;
      vga_buf_write      <= vga_buf_write_d;
      vga_buf_writedata  <= vga_buf_writedata_d;
      busy               <= busy_d;
      rect_count         <= rect_count_d;
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: mailbox SRAM model with 2-cycle read latency,
// pixel/ack monitor, and a plain-arithmetic fill reference.
module tb_rect_fill_engine;

  localparam int SW       = 640;
  localparam int SH       = 480;
  localparam int RL       = 2;
  localparam int MAX_ADDR = SW * SH - 1;
  localparam int LATENCY  = 5 * (RL + 1) + 1;

  logic        clk;
  logic        reset_n;
  logic [7:0]  sram_address;
  logic        sram_clken, sram_chipselect, sram_write;
  logic [31:0] sram_writedata;
  logic [3:0]  sram_byteenable;
  logic [31:0] sram_readdata;
  logic [18:0] vga_buf_address;
  logic        vga_buf_clken, vga_buf_chipselect, vga_buf_write;
  logic [7:0]  vga_buf_writedata;
  logic        busy;
  logic [15:0] rect_count;

  rect_fill_engine #(.SCREEN_W(SW), .SCREEN_H(SH), .RD_LAT(RL)) dut (
    .clk(clk), .reset_n(reset_n),
    .sram_address(sram_address), .sram_clken(sram_clken),
    .sram_chipselect(sram_chipselect), .sram_write(sram_write),
    .sram_writedata(sram_writedata), .sram_byteenable(sram_byteenable),
    .sram_readdata(sram_readdata),
    .vga_buf_address(vga_buf_address), .vga_buf_clken(vga_buf_clken),
    .vga_buf_chipselect(vga_buf_chipselect), .vga_buf_write(vga_buf_write),
    .vga_buf_writedata(vga_buf_writedata),
    .busy(busy), .rect_count(rect_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  // Mailbox SRAM: HPS writes come through hps_*, engine reads see two cycles of latency.
  logic [31:0] mem [256];
  logic [31:0] rd_pipe;
  logic        hps_we, clr_mem;
  logic [7:0]  hps_addr;
  logic [31:0] hps_data;

  always @(posedge clk) begin
    rd_pipe       <= (sram_chipselect && !sram_write) ? mem[sram_address] : $urandom;
    sram_readdata <= rd_pipe;
    if (clr_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    end else if (hps_we) begin
      mem[hps_addr] <= hps_data;
    end else if (sram_chipselect && sram_write && sram_byteenable == 4'hF) begin
      mem[sram_address] <= sram_writedata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, sampled on the falling edge.
  int   pix_addr[$], pix_data[$], pix_cyc[$], ack_cyc[$], poll_cyc[$];
  int   ack_bad, vga_cs_bad, vga_oob, busy_rise;
  logic busy_prev;
  logic mon_clr;

  always @(negedge clk) begin
    if (mon_clr) begin
      pix_addr.delete(); pix_data.delete(); pix_cyc.delete();
      ack_cyc.delete(); poll_cyc.delete();
      ack_bad    <= 0;
      vga_cs_bad <= 0;
      vga_oob    <= 0;
      busy_rise  <= -1;
    end else begin
      if (vga_buf_write) begin
        pix_addr.push_back(int'(vga_buf_address));
        pix_data.push_back(int'(vga_buf_writedata));
        pix_cyc.push_back(cyc);
        if (int'(vga_buf_address) > MAX_ADDR) vga_oob <= vga_oob + 1;
      end
      if (vga_buf_chipselect != vga_buf_write) vga_cs_bad <= vga_cs_bad + 1;
      if (sram_chipselect && sram_write) begin
        ack_cyc.push_back(cyc);
        if (sram_address != 8'd0 || sram_writedata != 32'd0) ack_bad <= ack_bad + 1;
      end
      if (sram_chipselect && !sram_write && sram_address == 8'd0) poll_cyc.push_back(cyc);
      if (busy && !busy_prev) busy_rise <= cyc;
    end
    busy_prev <= busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hps_write(input logic [7:0] a, input logic [31:0] d);
    hps_addr = a;
    hps_data = d;
    hps_we   = 1'b1;
    tick();
    hps_we   = 1'b0;
  endtask

  // Loads the mailbox with junk in the unused upper bits, go written last.
  task automatic start_cmd(input int x1, input int y1, input int x2, input int y2, input int col);
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
    hps_write(8'd1, {22'($urandom), 10'(x1)});
    hps_write(8'd2, {22'($urandom), 10'(y1)});
    hps_write(8'd3, {22'($urandom), 10'(x2)});
    hps_write(8'd4, {22'($urandom), 10'(y2)});
    hps_write(8'd5, {24'($urandom), 8'(col)});
    hps_write(8'd0, $urandom | 32'd1);
  endtask

  task automatic finish_cmd(input string name, input int x1, input int y1, input int x2,
                            input int y2, input int col);
    int  exp_a[$];
    int  cx2, cy2, n, last;
    bit  done, found;
    cx2 = (x2 > SW - 1) ? SW - 1 : x2;
    cy2 = (y2 > SH - 1) ? SH - 1 : y2;
    for (int yy = y1; yy <= cy2; yy++)
      for (int xx = x1; xx <= cx2; xx++) exp_a.push_back(xx + yy * SW);

    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      tick();
      done = (ack_cyc.size() > 0) && !busy;
    end
    tick();
    exp_count++;

    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s completion: got acks=%0d busy=%b, expected ack and busy low", name,
               ack_cyc.size(), busy);
    end
    checks++;
    if (pix_addr.size() !== exp_a.size()) begin
      errors++;
      $display("FAIL %s pixel count: got %0d, expected %0d", name, pix_addr.size(), exp_a.size());
    end
    n = (pix_addr.size() < exp_a.size()) ? pix_addr.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (pix_addr[i] !== exp_a[i] || pix_data[i] !== col) begin
        errors++;
        $display("FAIL %s pixel[%0d]: got addr=%0d data=%0h, expected addr=%0d data=%0h",
                 name, i, pix_addr[i], pix_data[i], exp_a[i], col);
      end
    end
    checks++;
    if (vga_cs_bad !== 0 || vga_oob !== 0) begin
      errors++;
      $display("FAIL %s vga strobes: got cs/write disagreements=%0d out-of-range=%0d, expected 0/0",
               name, vga_cs_bad, vga_oob);
    end
    checks++;
    if (ack_cyc.size() !== 1 || ack_bad !== 0) begin
      errors++;
      $display("FAIL %s ack write: got count=%0d bad=%0d, expected one write of 0 to address 0",
               name, ack_cyc.size(), ack_bad);
    end
    if (pix_cyc.size() > 0 && ack_cyc.size() > 0) begin
      last = pix_cyc.size() - 1;
      checks++;
      if (pix_cyc[last] - pix_cyc[0] !== last) begin
        errors++;
        $display("FAIL %s throughput: got span=%0d, expected %0d", name,
                 pix_cyc[last] - pix_cyc[0], last);
      end
      checks++;
      if (pix_cyc[0] - busy_rise !== LATENCY) begin
        errors++;
        $display("FAIL %s first pixel latency: got %0d, expected %0d", name,
                 pix_cyc[0] - busy_rise, LATENCY);
      end
      checks++;
      if (ack_cyc[0] - pix_cyc[last] !== 1) begin
        errors++;
        $display("FAIL %s last pixel to ack: got %0d, expected 1", name, ack_cyc[0] - pix_cyc[last]);
      end
    end else if (ack_cyc.size() > 0) begin
      checks++;
      if (ack_cyc[0] - busy_rise !== LATENCY) begin
        errors++;
        $display("FAIL %s empty ack latency: got %0d, expected %0d", name,
                 ack_cyc[0] - busy_rise, LATENCY);
      end
    end
    if (ack_cyc.size() > 0) begin
      found = 1'b0;
      foreach (poll_cyc[i]) if (poll_cyc[i] == ack_cyc[0] + 1) found = 1'b1;
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL %s poll after ack: got no poll issue at cycle %0d, expected one", name,
                 ack_cyc[0] + 1);
      end
    end
    checks++;
    if (mem[0] !== 32'd0 || rect_count !== 16'(exp_count) || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s status: got go=%0h count=%0d busy=%b, expected go=0 count=%0d busy=0",
               name, mem[0], rect_count, busy, 16'(exp_count));
    end
  endtask

  task automatic run_cmd(input string name, input int x1, input int y1, input int x2,
                         input int y2, input int col);
    start_cmd(x1, y1, x2, y2, col);
    finish_cmd(name, x1, y1, x2, y2, col);
  endtask

  task automatic test_reset();
    hps_we  = 1'b0;
    clr_mem = 1'b1;
    mon_clr = 1'b1;
    reset_n = 1'b1;
    #1;
    reset_n = 1'b0;
    repeat (4) tick();
    clr_mem = 1'b0;
    mon_clr = 1'b0;
    checks++;
    if ({sram_chipselect, sram_write, vga_buf_chipselect, vga_buf_write} !== 4'b0000) begin
      errors++;
      $display("FAIL reset strobes: got %b, expected 0000",
               {sram_chipselect, sram_write, vga_buf_chipselect, vga_buf_write});
    end
    checks++;
    if (busy !== 1'b0 || rect_count !== 16'd0) begin
      errors++;
      $display("FAIL reset status: got busy=%b count=%0d, expected 0/0", busy, rect_count);
    end
    checks++;
    if (sram_clken !== 1'b1 || vga_buf_clken !== 1'b1) begin
      errors++;
      $display("FAIL reset clken: got %b%b, expected 11", sram_clken, vga_buf_clken);
    end
    checks++;
    if (sram_address !== 8'd0 || vga_buf_address !== 19'd0 || vga_buf_writedata !== 8'd0) begin
      errors++;
      $display("FAIL reset buses: got sa=%0d va=%0d vd=%0h, expected 0", sram_address,
               vga_buf_address, vga_buf_writedata);
    end
    checks++;
    if (sram_writedata !== 32'd0 || sram_byteenable !== 4'hF) begin
      errors++;
      $display("FAIL reset sram constants: got wd=%0h be=%0h, expected 0/f", sram_writedata,
               sram_byteenable);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (sram_chipselect !== 1'b1 || sram_write !== 1'b0 || sram_address !== 8'd0) begin
      errors++;
      $display("FAIL first poll: got cs=%b wr=%b addr=%0d, expected 1/0/0", sram_chipselect,
               sram_write, sram_address);
    end
  endtask

  task automatic test_basic();
    run_cmd("basic", 10, 20, 12, 21, 8'hE0);
  endtask

  task automatic test_corner();
    run_cmd("corner", 639, 479, 639, 479, 8'h1C);
  endtask

  task automatic test_clip();
    run_cmd("clip", 638, 478, 1000, 600, 8'h03);
  endtask

  task automatic test_empty();
    run_cmd("empty", 100, 5, 50, 5, 8'h55);
  endtask

  task automatic test_back_to_back();
    run_cmd("b2b_a", 0, 0, 3, 0, 8'hA5);
    run_cmd("b2b_b", 4, 0, 4, 2, 8'h5A);
  endtask

  task automatic test_random();
    int x1, y1, x2, y2, col;
    for (int n = 0; n < 12; n++) begin
      x1  = (n % 3 == 0) ? int'($urandom_range(630, 700)) : int'($urandom_range(0, 639));
      y1  = (n % 3 == 1) ? int'($urandom_range(470, 520)) : int'($urandom_range(0, 479));
      x2  = x1 + int'($urandom_range(0, 6)) - ((n % 5 == 4) ? 7 : 0);
      y2  = y1 + int'($urandom_range(0, 4));
      x2  = (x2 < 0) ? 0 : x2;
      col = int'($urandom_range(0, 255));
      run_cmd("random", x1, y1, x2, y2, col);
    end
  endtask

  task automatic test_reset_mid_draw();
    bit found;
    start_cmd(200, 100, 203, 103, 8'h7E);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      found = vga_buf_write && (pix_addr.size() == 2);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_draw third pixel: got pixels=%0d, expected third pixel on bus",
               pix_addr.size());
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({sram_chipselect, sram_write, vga_buf_chipselect, vga_buf_write, busy} !== 5'b0 ||
        rect_count !== 16'd0 || vga_buf_address !== 19'd0 || vga_buf_writedata !== 8'd0) begin
      errors++;
      $display("FAIL mid_draw reset outputs: got strobes=%b count=%0d va=%0d vd=%0h, expected 0",
               {sram_chipselect, sram_write, vga_buf_chipselect, vga_buf_write, busy},
               rect_count, vga_buf_address, vga_buf_writedata);
    end
    mon_clr = 1'b1;
    repeat (3) tick();
    mon_clr   = 1'b0;
    reset_n   = 1'b1;
    exp_count = 0;
    finish_cmd("mid_draw", 200, 100, 203, 103, 8'h7E);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corner();
    test_clip();
    test_empty();
    test_back_to_back();
    test_random();
    test_reset_mid_draw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
